// File: rtl/lut_cfg_writer.sv
// Configuration writer: parses SYNC/IDX/INIT/CHK byte frames and
// commits checked INIT words into per-slice LUT registers.
module lut_cfg_writer #(
  parameter int          K        = 4,
  parameter int          N_SLICES = 8,
  parameter logic [7:0]  SYNC     = 8'hA5
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [7:0]                    IN_DATA,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [N_SLICES*(2**K)-1:0]    CFG_INIT,
  output logic [N_SLICES-1:0]           CFG_LOADED,
  output logic                          WR_STROBE,
  output logic [7:0]                    WR_INDEX,
  output logic                          ERR,
  output logic [1:0]                    ERR_CODE
);

  localparam int W  = 2**K;
  localparam int B  = W / 8;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_INDEX,
    S_DATA,
    S_CHECK,
    S_COMMIT
  } state_t;

  state_t          r_state;
  logic [7:0]      r_idx;
  logic [7:0]      r_chk;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_stage;
  logic            r_bad;
  logic            w_acc;

  assign w_acc = IN_VALID && IN_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_HUNT;
      r_idx      <= '0;
      r_chk      <= '0;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_bad      <= 1'b0;
      IN_READY   <= 1'b0;
      CFG_INIT   <= '0;
      CFG_LOADED <= '0;
      WR_STROBE  <= 1'b0;
      WR_INDEX   <= '0;
      ERR        <= 1'b0;
      ERR_CODE   <= '0;
    end else begin
      WR_STROBE <= 1'b0;
      ERR       <= 1'b0;
      IN_READY  <= 1'b1;
      unique case (r_state)
        S_HUNT: begin
          if (w_acc && IN_DATA == SYNC)
            r_state <= S_INDEX;
        end
        S_INDEX: begin
          if (w_acc) begin
            r_idx   <= IN_DATA;
            r_chk   <= IN_DATA;
            r_cnt   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_stage[{r_cnt, 3'b000} +: 8] <= IN_DATA;
            r_chk <= r_chk ^ IN_DATA;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(B - 1))
              r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // ready drops here so it is low for exactly the COMMIT cycle
          if (w_acc) begin
            r_bad    <= (IN_DATA != r_chk);
            r_state  <= S_COMMIT;
            IN_READY <= 1'b0;
          end
        end
        S_COMMIT: begin
          if (r_bad) begin
            ERR      <= 1'b1;
            ERR_CODE <= 2'b01;
          end else if (r_idx >= 8'(N_SLICES)) begin
            ERR      <= 1'b1;
            ERR_CODE <= 2'b10;
          end else begin
            for (int s = 0; s < N_SLICES; s++) begin
              if (r_idx == 8'(s)) begin
                CFG_INIT[s*W +: W] <= r_stage;
                CFG_LOADED[s]      <= 1'b1;
              end
            end
            WR_INDEX  <= r_idx;
            WR_STROBE <= 1'b1;
          end
          r_state <= S_HUNT;
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Bench for lut_cfg_writer: frame-level model checked every cycle,
// plus directed frames with literal expectations.
module tb_lut_cfg_writer;

  localparam int K  = 4;
  localparam int NS = 8;
  localparam int W  = 2**K;
  localparam int B  = W / 8;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [NS*W-1:0]   CFG_INIT;
  logic [NS-1:0]     CFG_LOADED;
  logic              WR_STROBE;
  logic [7:0]        WR_INDEX;
  logic              ERR;
  logic [1:0]        ERR_CODE;

  int n_tests = 0;
  int n_fail  = 0;

  lut_cfg_writer #(.K(K), .N_SLICES(NS), .SYNC(8'hA5)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_DATA    (IN_DATA),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .CFG_INIT   (CFG_INIT),
    .CFG_LOADED (CFG_LOADED),
    .WR_STROBE  (WR_STROBE),
    .WR_INDEX   (WR_INDEX),
    .ERR        (ERR),
    .ERR_CODE   (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collects accepted bytes, judges whole frames
  logic [W-1:0] m_init [NS];
  logic [NS-1:0] m_loaded;
  logic [7:0]   m_widx;
  logic [1:0]   m_code;
  logic         m_strobe, m_err, m_ready, m_hunt, m_pend;
  logic [7:0]   m_fb [B+2];
  int           m_pos;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < NS; s++) m_init[s] = '0;
      m_loaded = '0; m_widx = '0; m_code = '0;
      m_strobe = 0; m_err = 0; m_ready = 0;
      m_hunt = 1; m_pend = 0; m_pos = 0;
    end else begin
      m_strobe = 0;
      m_err    = 0;
      if (m_pend) begin
        logic [7:0]   sum;
        logic [W-1:0] word;
        sum = m_fb[0];
        for (int i = 1; i <= B; i++) begin
          sum = sum ^ m_fb[i];
          word[(i-1)*8 +: 8] = m_fb[i];
        end
        if (sum != m_fb[B+1]) begin
          m_err = 1; m_code = 2'b01;
        end else if (int'(m_fb[0]) >= NS) begin
          m_err = 1; m_code = 2'b10;
        end else begin
          m_init[m_fb[0]]   = word;
          m_loaded[m_fb[0]] = 1'b1;
          m_widx   = m_fb[0];
          m_strobe = 1;
        end
        m_pend = 0;
      end else if (IN_VALID && m_ready) begin
        if (m_hunt) begin
          if (IN_DATA == 8'hA5) begin
            m_hunt = 0;
            m_pos  = 0;
          end
        end else begin
          m_fb[m_pos] = IN_DATA;
          m_pos++;
          if (m_pos == B + 2) begin
            m_pend = 1;
            m_hunt = 1;
          end
        end
      end
      m_ready = !m_pend;
    end
  end

  always @(negedge CLK) begin
    logic [NS*W-1:0] e;
    for (int s = 0; s < NS; s++) e[s*W +: W] = m_init[s];
    chk("m_init",   CFG_INIT,   e);
    chk("m_loaded", CFG_LOADED, m_loaded);
    chk("m_widx",   WR_INDEX,   m_widx);
    chk("m_code",   ERR_CODE,   m_code);
    chk("m_strobe", WR_STROBE,  m_strobe);
    chk("m_err",    ERR,        m_err);
    chk("m_ready",  IN_READY,   m_ready);
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    IN_DATA  = b;
    IN_VALID = 1'b1;
    t = 0;
    while (!IN_READY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("ready_wait", t < 20, 1'b1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] i,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] c, input int gmax);
    send(a,  $urandom_range(0, gmax));
    send(i,  $urandom_range(0, gmax));
    send(d0, $urandom_range(0, gmax));
    send(d1, $urandom_range(0, gmax));
    send(c,  $urandom_range(0, gmax));
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (!(WR_STROBE || ERR) && t < 8) begin
      @(negedge CLK);
      t++;
    end
    chk("result_wait", t < 8, 1'b1);
  endtask

  initial begin
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_init",   CFG_INIT,   '0);
    chk("rst_loaded", CFG_LOADED, '0);
    chk("rst_ready",  IN_READY,   1'b0);
    chk("rst_code",   ERR_CODE,   2'b00);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("ready_up", IN_READY, 1'b1);

    frame(8'hA5, 8'h02, 8'h34, 8'h12, 8'h24, 0);
    @(negedge CLK);
    chk("t1_ready_low", IN_READY, 1'b0);
    wait_result();
    chk("t1_strobe", WR_STROBE, 1'b1);
    chk("t1_err",    ERR,       1'b0);
    chk("t1_widx",   WR_INDEX,  8'd2);
    chk("t1_slice2", CFG_INIT[47:32], 16'h1234);
    chk("t1_loaded", CFG_LOADED, 8'h04);
    chk("t1_ready",  IN_READY,  1'b1);

    frame(8'hA5, 8'h02, 8'h34, 8'h12, 8'h25, 0);
    @(negedge CLK);
    wait_result();
    chk("t2_err",    ERR,       1'b1);
    chk("t2_code",   ERR_CODE,  2'b01);
    chk("t2_slice2", CFG_INIT[47:32], 16'h1234);
    chk("t2_loaded", CFG_LOADED, 8'h04);
    chk("t2_widx",   WR_INDEX,  8'd2);

    frame(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09, 0);
    @(negedge CLK);
    wait_result();
    chk("t3_err",    ERR,       1'b1);
    chk("t3_code",   ERR_CODE,  2'b10);
    chk("t3_strobe", WR_STROBE, 1'b0);

    send(8'h00, 2);
    send(8'hFF, 1);
    frame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01, 3);
    @(negedge CLK);
    wait_result();
    chk("t4_strobe", WR_STROBE, 1'b1);
    chk("t4_widx",   WR_INDEX,  8'd1);
    chk("t4_slice1", CFG_INIT[31:16], 16'hA5A5);
    chk("t4_loaded", CFG_LOADED, 8'h06);

    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'h34, 0);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    chk("t5_rst_init",   CFG_INIT,   '0);
    chk("t5_rst_loaded", CFG_LOADED, '0);
    chk("t5_rst_strobe", WR_STROBE,  1'b0);
    chk("t5_rst_err",    ERR,        1'b0);
    chk("t5_rst_widx",   WR_INDEX,   8'd0);
    chk("t5_rst_ready",  IN_READY,   1'b0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t5_no_strobe", CFG_LOADED, 8'h00);
    frame(8'hA5, 8'h00, 8'hCD, 8'hAB, 8'h66, 1);
    @(negedge CLK);
    wait_result();
    chk("t5_strobe", WR_STROBE, 1'b1);
    chk("t5_widx",   WR_INDEX,  8'd0);
    chk("t5_slice0", CFG_INIT[15:0], 16'hABCD);
    chk("t5_loaded", CFG_LOADED, 8'h01);

    frame(8'hA5, 8'h05, 8'hFF, 8'hFF, 8'h05, 0);
    @(negedge CLK);
    wait_result();
    chk("t6a_slice5", CFG_INIT[95:80], 16'hFFFF);
    frame(8'hA5, 8'h05, 8'h01, 8'h00, 8'h04, 0);
    @(negedge CLK);
    wait_result();
    chk("t6b_slice5", CFG_INIT[95:80], 16'h0001);
    chk("t6b_loaded", CFG_LOADED, 8'h21);
    chk("t6b_slice0", CFG_INIT[15:0], 16'hABCD);
    chk("t6b_others", CFG_INIT[79:16], 64'h0);

    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_cfg_writer.md
Name: lut_cfg_writer

Overview:
- Configuration writer for the generic logic slices: turns a byte-serial configuration stream into per-slice LUT INIT words and load flags.
- Slices consume INIT as static truth-table content. This block is the producing end: it parses, checks and commits the content at run time.
- Sits between the board-level configuration port (UART/SPI byte front end) and the slice array.

Parameters:
- K, 4: LUT input count. INIT word is 2**K bits; legal K = 3..6.
- N_SLICES, 8: number of slice INIT registers; legal 1..255.
- SYNC, 8'hA5: frame start byte.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  byte accepted when IN_VALID && IN_READY at a CLK edge.
- CFG_INIT  out  N_SLICES*2**K  concatenated INIT words; slice s at bits [s*2**K +: 2**K].
- CFG_LOADED  out  N_SLICES  bit s set once slice s has committed at least once.
- WR_STROBE  out  1  one-cycle pulse on a commit.
- WR_INDEX  out  8  slice index of the last commit; stable until the next commit.
- ERR  out  1  one-cycle pulse on a rejected frame.
- ERR_CODE  out  2  01 = bad checksum, 10 = index out of range; holds until the next ERR.

Behaviour:
- Reset (async, RST_N=0):
  - state = HUNT; IN_READY = 0.
  - CFG_INIT, CFG_LOADED, WR_STROBE, WR_INDEX, ERR, ERR_CODE all 0.
  - First cycle after release: IN_READY = 1.
- Frame format, in accepted-byte order: SYNC, IDX, B = 2**K/8 INIT bytes (least-significant byte first), CHK.
  - CHK = XOR of IDX and all INIT bytes.
  - For K = 3: B = 1; the INIT byte is used in full.
- States:
  - HUNT: discard each accepted byte until one equals SYNC, then go to INDEX.
  - INDEX: latch IDX; clear byte counter; go to DATA.
  - DATA: shift byte into staging word at position counter*8; XOR into running checksum.
    - Counter increments per accepted byte.
    - After byte B-1, go to CHECK.
  - CHECK: compare the accepted byte with the running checksum (which started at IDX), then go to COMMIT.
  - COMMIT: IN_READY = 0 for exactly this one cycle; evaluate in priority order:
    - If checksum mismatches: ERR=1, ERR_CODE=01.
    - Else if IDX >= N_SLICES: ERR=1, ERR_CODE=10.
    - Else: CFG_INIT slice IDX = staging, CFG_LOADED[IDX] = 1, WR_INDEX = IDX, WR_STROBE = 1.
    - Next state is always HUNT.
- Timing and handshake:
  - WR_STROBE/ERR are registered and high in the cycle after COMMIT; CFG_INIT update is visible in that same cycle.
  - Commit latency: 1 cycle after the CHK byte handshake.
  - IN_READY is 1 in all states except COMMIT and reset.
  - IN_VALID low stalls the parser indefinitely with no timeout; state and partial frame are kept.
- SYNC value is not special outside HUNT: 0xA5 inside IDX/INIT/CHK is plain data; no resynchronisation mid-frame.
- Re-writing a slice overwrites its INIT. CFG_LOADED bits only clear on reset.
- Rejected frames leave CFG_INIT, CFG_LOADED and WR_INDEX unchanged.
- Reset mid-frame: the partial frame is discarded; no strobe or error is produced.
- Other slices' INIT bits never change on a commit.

Test Plan:
- Reset with RST_N low, then stream A5 02 34 12 24 (K=4) -> one cycle after the CHK byte: WR_STROBE=1, WR_INDEX=2, CFG_INIT[47:32]=16'h1234, CFG_LOADED=8'h04, ERR=0; IN_READY=0 for exactly one cycle.
- Stream A5 02 34 12 25 -> ERR=1 with ERR_CODE=01; CFG_INIT, CFG_LOADED and WR_INDEX unchanged; IN_READY returns to 1.
- Stream A5 09 00 00 09 (N_SLICES=8) -> ERR=1 with ERR_CODE=10; no WR_STROBE.
- Stream 00 FF A5 01 A5 A5 01 with random IN_VALID gaps -> leading garbage skipped; in-frame A5 bytes treated as data; commit slice 1 = 16'hA5A5.
- Pull RST_N low after A5 03 34, release, then send a valid frame for slice 0 -> all outputs 0 during reset; no strobe for slice 3; slice 0 commits normally.
- Write slice 5 with 16'hFFFF, then with 16'h0001 -> second commit overwrites to 16'h0001; CFG_LOADED[5] stays 1; other slices unchanged.
